ones_frame_acc: RTL and testbench

Downstream stage of the 7-bit ones counter (count_73). Consumes one 3-bit per-word ones count per accepted beat and accumulates the counts over a frame of words. Presents the frame total, word count and an overflow flag to the consumer through a valid/ready handshake. A frame ends on an explicit last marker or when the word limit is reached.

---
 rtl/ones_pkg.sv | 13 +
 rtl/ones_sat_add.sv | 21 ++
 rtl/ones_frame_acc.sv | 101 ++++++++++
 tb/tb_ones_frame_acc.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ones_pkg.sv
// Shared definitions for the frame ones accumulator: state encoding and
// datapath widths used by the accumulator and its saturating adder.
package ones_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  localparam int COUNT_W       = 3;
  localparam int SUM_W_DEFAULT = 10;

endpackage

// File: rtl/ones_sat_add.sv
// Saturating add of a 3-bit per-word ones count onto the frame total.
// sat is asserted when the true sum would exceed the all-ones maximum.
module ones_sat_add
  import ones_pkg::*;
#(
  parameter int SUM_W = SUM_W_DEFAULT
) (
  input  logic [SUM_W-1:0]   a,
  input  logic [COUNT_W-1:0] b,
  output logic [SUM_W-1:0]   y,
  output logic               sat
);

  logic [SUM_W:0] wide;

  // One guard bit is enough: the operand never exceeds 7.
  assign wide = {1'b0, a} + {{(SUM_W + 1 - COUNT_W){1'b0}}, b};
  assign sat  = wide[SUM_W];
  assign y    = sat ? {SUM_W{1'b1}} : wide[SUM_W-1:0];

endmodule

// File: rtl/ones_frame_acc.sv
// Accumulates per-word ones counts over a frame and hands the frame total,
// word count and status flags to the consumer over a valid/ready handshake.
module ones_frame_acc
  import ones_pkg::*;
#(
  parameter int SUM_W     = SUM_W_DEFAULT,
  parameter int MAX_WORDS = 64,
  parameter int WCNT_W    = 7
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [COUNT_W-1:0] in_count,
  input  logic               in_last,
  output logic               sum_valid,
  input  logic               sum_ready,
  output logic [SUM_W-1:0]   sum,
  output logic [WCNT_W-1:0]  words,
  output logic               overflow,
  output logic               forced
);

  state_t              state, state_next;
  logic [SUM_W-1:0]    acc, acc_add;
  logic                sat;
  logic [WCNT_W-1:0]   wcnt, wcnt_inc;
  logic                ovf, ovf_next;
  logic                accept, close, at_limit, release_hold;

  ones_sat_add #(.SUM_W(SUM_W)) u_sat_add (
    .a  (acc),
    .b  (in_count),
    .y  (acc_add),
    .sat(sat)
  );

  // Handshake outputs decode only the registered state, so neither ready
  // nor valid depends combinationally on the opposite side.
  always_comb begin
    state_next   = state;
    in_ready     = 1'b0;
    sum_valid    = 1'b0;
    accept       = 1'b0;
    close        = 1'b0;
    release_hold = 1'b0;
    wcnt_inc     = wcnt + WCNT_W'(1);
    at_limit     = (wcnt_inc == WCNT_W'(MAX_WORDS));
    ovf_next     = ovf | sat;
    case (state)
      ACCUM: begin
        in_ready = 1'b1;
        accept   = in_valid;
        close    = in_valid & (in_last | at_limit);
        if (close) state_next = HOLD;
      end
      HOLD: begin
        sum_valid    = 1'b1;
        release_hold = sum_ready;
        if (sum_ready) state_next = ACCUM;
      end
      default: state_next = ACCUM;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ACCUM;
    else     state <= state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc      <= '0;
      wcnt     <= '0;
      ovf      <= 1'b0;
      sum      <= '0;
      words    <= '0;
      overflow <= 1'b0;
      forced   <= 1'b0;
    end else begin
      if (accept) begin
        acc  <= acc_add;
        wcnt <= wcnt_inc;
        ovf  <= ovf_next;
      end
      if (close) begin
        sum      <= acc_add;
        words    <= wcnt_inc;
        overflow <= ovf_next;
        forced   <= at_limit & ~in_last;
      end
      // Running totals are wiped only once the consumer takes the result.
      if (release_hold) begin
        acc  <= '0;
        wcnt <= '0;
        ovf  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ones_frame_acc.sv
// Self-checking bench for ones_frame_acc: directed scenarios plus random
// frames compared against an arithmetic model of the frame total.
module tb_ones_frame_acc;

  logic clk = 1'b0;
  logic rst;
  logic in_valid, in_last, sum_ready, sel;
  logic [2:0] in_count;

  logic       a_in_ready, a_sum_valid, a_overflow, a_forced;
  logic [9:0] a_sum;
  logic [6:0] a_words;
  logic       b_in_ready, b_sum_valid, b_overflow, b_forced;
  logic [5:0] b_sum;
  logic [6:0] b_words;

  logic       o_in_ready, o_sum_valid, o_overflow, o_forced;
  logic [9:0] o_sum;
  logic [6:0] o_words;

  int n_checks = 0;
  int n_fail   = 0;
  int cq[$];
  int last_sum, last_words;

  always #5 clk = ~clk;

  ones_frame_acc dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid & ~sel), .in_ready(a_in_ready),
    .in_count(in_count), .in_last(in_last),
    .sum_valid(a_sum_valid), .sum_ready(sum_ready & ~sel),
    .sum(a_sum), .words(a_words), .overflow(a_overflow), .forced(a_forced)
  );

  ones_frame_acc #(.SUM_W(6), .MAX_WORDS(64), .WCNT_W(7)) dut6 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid & sel), .in_ready(b_in_ready),
    .in_count(in_count), .in_last(in_last),
    .sum_valid(b_sum_valid), .sum_ready(sum_ready & sel),
    .sum(b_sum), .words(b_words), .overflow(b_overflow), .forced(b_forced)
  );

  assign o_in_ready  = sel ? b_in_ready  : a_in_ready;
  assign o_sum_valid = sel ? b_sum_valid : a_sum_valid;
  assign o_sum       = sel ? {4'b0, b_sum} : a_sum;
  assign o_words     = sel ? b_words     : a_words;
  assign o_overflow  = sel ? b_overflow  : a_overflow;
  assign o_forced    = sel ? b_forced    : a_forced;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Drives the frame held in cq and checks the result one cycle after the
  // closing beat. Model: total = plain sum, clipped to the width maximum.
  task automatic run_frame(input string name, input bit with_last, input bit gaps,
                           input int sum_w, input int max_words);
    int total = 0;
    int maxv  = (1 << sum_w) - 1;
    int n     = cq.size();
    int exp_sum;
    bit exp_ovf, exp_forced;
    for (int i = 0; i < n; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        in_count = 3'($urandom);
        in_last  = 1'($urandom);
        step();
      end
      in_valid = 1'b1;
      in_count = 3'(cq[i]);
      in_last  = with_last && (i == n - 1);
      n_checks++;
      if (o_in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL %s in_ready beat %0d: got %b expected 1", name, i, o_in_ready);
      end
      step();
      total += cq[i];
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    exp_sum    = (total > maxv) ? maxv : total;
    exp_ovf    = (total > maxv);
    exp_forced = !with_last && (n == max_words);
    n_checks += 6;
    if (o_sum_valid !== 1'b1) begin
      n_fail++; $display("FAIL %s sum_valid: got %b expected 1", name, o_sum_valid);
    end
    if (o_in_ready !== 1'b0) begin
      n_fail++; $display("FAIL %s in_ready in hold: got %b expected 0", name, o_in_ready);
    end
    if (o_sum !== 10'(exp_sum)) begin
      n_fail++; $display("FAIL %s sum: got %0d expected %0d", name, o_sum, exp_sum);
    end
    if (o_words !== 7'(n)) begin
      n_fail++; $display("FAIL %s words: got %0d expected %0d", name, o_words, n);
    end
    if (o_overflow !== exp_ovf) begin
      n_fail++; $display("FAIL %s overflow: got %b expected %b", name, o_overflow, exp_ovf);
    end
    if (o_forced !== exp_forced) begin
      n_fail++; $display("FAIL %s forced: got %b expected %b", name, o_forced, exp_forced);
    end
    last_sum   = exp_sum;
    last_words = n;
  endtask

  task automatic consume(input string name);
    sum_ready = 1'b1;
    step();
    sum_ready = 1'b0;
    n_checks += 3;
    if (o_sum_valid !== 1'b0 || o_in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s release: got valid=%b ready=%b expected valid=0 ready=1",
               name, o_sum_valid, o_in_ready);
    end
    if (o_sum !== 10'(last_sum)) begin
      n_fail++; $display("FAIL %s sum held in accum: got %0d expected %0d", name, o_sum, last_sum);
    end
    if (o_words !== 7'(last_words)) begin
      n_fail++; $display("FAIL %s words held in accum: got %0d expected %0d", name, o_words, last_words);
    end
  endtask

  task automatic test_reset;
    n_checks += 2;
    if (o_sum_valid !== 1'b0 || o_in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset handshake: got valid=%b ready=%b expected valid=0 ready=1",
               o_sum_valid, o_in_ready);
    end
    if (o_sum !== 10'd0 || o_words !== 7'd0 || o_overflow !== 1'b0 || o_forced !== 1'b0) begin
      n_fail++;
      $display("FAIL reset outputs: got sum=%0d words=%0d ovf=%b frc=%b expected all 0",
               o_sum, o_words, o_overflow, o_forced);
    end
  endtask

  task automatic test_basic;
    cq = '{3, 7, 0, 5};
    run_frame("basic", 1'b1, 1'b0, 10, 64);
    consume("basic");
  endtask

  task automatic test_forced;
    cq = {};
    for (int i = 0; i < 64; i++) cq.push_back(7);
    run_frame("forced_nolast", 1'b0, 1'b0, 10, 64);
    consume("forced_nolast");
    run_frame("forced_withlast", 1'b1, 1'b0, 10, 64);
    consume("forced_withlast");
  endtask

  task automatic test_saturation;
    sel = 1'b1;
    cq = {};
    for (int i = 0; i < 9; i++) cq.push_back(7);
    run_frame("sat_exact63", 1'b1, 1'b0, 6, 64);
    consume("sat_exact63");
    cq.push_back(7);
    run_frame("sat_over", 1'b1, 1'b0, 6, 64);
    consume("sat_over");
    sel = 1'b0;
  endtask

  task automatic test_hold_backpressure;
    cq = '{1, 2};
    run_frame("hold_setup", 1'b1, 1'b0, 10, 64);
    in_valid  = 1'b1;
    in_count  = 3'd7;
    in_last   = 1'b1;
    sum_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      n_checks += 2;
      if (o_in_ready !== 1'b0 || o_sum_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL hold cycle %0d handshake: got ready=%b valid=%b expected ready=0 valid=1",
                 i, o_in_ready, o_sum_valid);
      end
      if (o_sum !== 10'd3 || o_words !== 7'd2) begin
        n_fail++;
        $display("FAIL hold cycle %0d stable: got sum=%0d words=%0d expected sum=3 words=2",
                 i, o_sum, o_words);
      end
    end
    sum_ready = 1'b1;
    step();
    sum_ready = 1'b0;
    n_checks++;
    if (o_in_ready !== 1'b1 || o_sum_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL hold release: got ready=%b valid=%b expected ready=1 valid=0",
               o_in_ready, o_sum_valid);
    end
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
    n_checks++;
    if (o_sum_valid !== 1'b1 || o_sum !== 10'd7 || o_words !== 7'd1) begin
      n_fail++;
      $display("FAIL hold next frame: got valid=%b sum=%0d words=%0d expected valid=1 sum=7 words=1",
               o_sum_valid, o_sum, o_words);
    end
    last_sum   = 7;
    last_words = 1;
    consume("hold_next");
  endtask

  task automatic test_single_beat;
    cq = '{0};
    run_frame("single_zero", 1'b1, 1'b0, 10, 64);
    consume("single_zero");
  endtask

  task automatic test_back_to_back;
    int results = 0;
    int c;
    bit exp_acc;
    in_valid  = 1'b1;
    in_last   = 1'b1;
    sum_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      c = int'($urandom_range(0, 7));
      in_count = 3'(c);
      exp_acc  = (i % 2 == 0);
      n_checks++;
      if (o_in_ready !== exp_acc) begin
        n_fail++;
        $display("FAIL b2b cycle %0d in_ready: got %b expected %b", i, o_in_ready, exp_acc);
      end
      step();
      if (o_sum_valid === 1'b1) results++;
      n_checks++;
      if (exp_acc) begin
        if (o_sum_valid !== 1'b1 || o_sum !== 10'(c) || o_words !== 7'd1) begin
          n_fail++;
          $display("FAIL b2b cycle %0d result: got valid=%b sum=%0d words=%0d expected valid=1 sum=%0d words=1",
                   i, o_sum_valid, o_sum, o_words, c);
        end
      end else if (o_sum_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL b2b cycle %0d bubble: got valid=%b expected 0", i, o_sum_valid);
      end
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    sum_ready = 1'b0;
    n_checks++;
    if (results != 10) begin
      n_fail++; $display("FAIL b2b result count: got %0d expected 10", results);
    end
  endtask

  task automatic test_reset_midframe;
    in_valid = 1'b1;
    in_last  = 1'b0;
    in_count = 3'd5;
    for (int i = 0; i < 3; i++) step();
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (o_sum_valid !== 1'b0 || o_in_ready !== 1'b1 || o_sum !== 10'd0 || o_words !== 7'd0) begin
      n_fail++;
      $display("FAIL midframe reset: got valid=%b ready=%b sum=%0d words=%0d expected 0/1/0/0",
               o_sum_valid, o_in_ready, o_sum, o_words);
    end
    step();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if (o_sum_valid !== 1'b0) begin
        n_fail++; $display("FAIL post reset idle %0d: got valid=%b expected 0", i, o_sum_valid);
      end
    end
    cq = '{2, 2};
    run_frame("after_reset", 1'b1, 1'b0, 10, 64);
    consume("after_reset");
  endtask

  task automatic test_random;
    int len;
    for (int f = 0; f < 15; f++) begin
      cq  = {};
      len = (f % 5 == 4) ? 64 : int'($urandom_range(1, 12));
      for (int i = 0; i < len; i++) cq.push_back(int'($urandom_range(0, 7)));
      run_frame($sformatf("random%0d", f), (len != 64) || ($urandom_range(0, 1) == 1),
                1'b1, 10, 64);
      repeat ($urandom_range(0, 2)) step();
      consume($sformatf("random%0d", f));
    end
  endtask

  initial begin
    rst       = 1'b1;
    sel       = 1'b0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    in_count  = 3'd0;
    sum_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    rst = 1'b0;
    step();
    test_reset();
    test_basic();
    test_forced();
    test_saturation();
    test_hold_backpressure();
    test_single_beat();
    test_back_to_back();
    test_reset_midframe();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
